// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one free-running fpu adder between two requesters
//
// Two requesters hand operand pairs over valid/ready. One pair at a time is
// driven onto the fpu, held for FPU_CYCLES clocks so the free-running adder
// settles, then the result is captured and returned over the granted
// requester's response channel.
//
// Ports:
//   clock100KHz            system clock, rising edge
//   reset                  synchronous, active-low
//   req{0,1}_valid/ready   operand handshake; req{0,1}_a/_b operands
//   rsp{0,1}_valid/ready   result handshake; rsp{0,1}_data/_status result
//   fpu_op_a/_b            operands to the fpu, held across the settle window
//   fpu_data_in/status_in  fpu result
//   busy                   any state other than IDLE
//   grant_id               requester owning the fpu, valid while busy
//   ops_done               completed transactions, wraps
module fpu_arbiter #(
  parameter int FPU_CYCLES = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic [3:0]       rsp0_status,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic [3:0]       rsp1_status,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  input  logic [31:0]      fpu_data_in,
  input  logic [3:0]       fpu_status_in,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_RESPOND} state_t;

  localparam logic [7:0] LP_LOAD = 8'(FPU_CYCLES - 1);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_rr;
  logic             r_grant;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [31:0]      r_rsp0_data;
  logic [31:0]      r_rsp1_data;
  logic [3:0]       r_rsp0_status;
  logic [3:0]       r_rsp1_status;
  logic [CNT_W-1:0] r_ops;

  logic w_idle;
  logic w_grant;
  logic w_accept;
  logic w_rsp_ready;

  // Contention goes to the round-robin pointer; a lone request wins outright.
  assign w_grant     = (req0_valid && req1_valid) ? r_rr : req1_valid;
  // Readies are gated by reset so nothing looks accepted while reset is held.
  assign w_idle      = (r_state == S_IDLE) && reset;
  assign req0_ready  = w_idle && req0_valid && !w_grant;
  assign req1_ready  = w_idle && req1_valid && w_grant;
  assign w_accept    = req0_ready || req1_ready;
  assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rr          <= 1'b0;
      r_grant       <= 1'b0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_data   <= '0;
      r_rsp1_data   <= '0;
      r_rsp0_status <= '0;
      r_rsp1_status <= '0;
      r_ops         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a  <= w_grant ? req1_a : req0_a;
            r_op_b  <= w_grant ? req1_b : req0_b;
            r_grant <= w_grant;
            r_cnt   <= LP_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Operands stay put; the fpu result is only trusted after the window.
          if (r_cnt == 8'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (r_grant) begin
            r_rsp1_data   <= fpu_data_in;
            r_rsp1_status <= fpu_status_in;
            r_rsp1_valid  <= 1'b1;
          end else begin
            r_rsp0_data   <= fpu_data_in;
            r_rsp0_status <= fpu_status_in;
            r_rsp0_valid  <= 1'b1;
          end
          r_state <= S_RESPOND;
        end
        S_RESPOND: begin
          if (w_rsp_ready) begin
            if (r_grant) r_rsp1_valid <= 1'b0;
            else         r_rsp0_valid <= 1'b0;
            r_ops   <= r_ops + 1'b1;
            // Pointer moves only on completion so the loser gets the next turn.
            r_rr    <= ~r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fpu_op_a    = r_op_a;
  assign fpu_op_b    = r_op_b;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_data   = r_rsp0_data;
  assign rsp1_data   = r_rsp1_data;
  assign rsp0_status = r_rsp0_status;
  assign rsp1_status = r_rsp1_status;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
  assign ops_done    = r_ops;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - self-checking bench for fpu_arbiter with stub fpu and reference model
module tb_fpu_arbiter;

  localparam int F  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_v;
  logic [31:0]   req_a [2];
  logic [31:0]   req_b [2];
  logic [1:0]    rsp_rdy;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_data, rsp1_data;
  logic [3:0]    rsp0_status, rsp1_status;
  logic [31:0]   fpu_op_a, fpu_op_b, fpu_data_in;
  logic [3:0]    fpu_status_in;
  logic          busy, grant_id;
  logic [CW-1:0] ops_done;

  logic          fix_en;
  logic [31:0]   fix_data;
  logic [3:0]    fix_st;

  int            checks = 0;
  int            failures = 0;

  // Reference model: who was served last, completed count, pending requests.
  int            last_g;
  logic [CW-1:0] m_ops;
  logic [1:0]    pend;

  always #5 clk = ~clk;

  // Stub fpu: a combinational function of the held operands.
  assign fpu_data_in   = fix_en ? fix_data : (fpu_op_a + fpu_op_b);
  assign fpu_status_in = fix_en ? fix_st : (fpu_op_a[3:0] ^ fpu_op_b[7:4]);

  fpu_arbiter #(.FPU_CYCLES(F), .CNT_W(CW)) dut (
    .clock100KHz(clk), .reset(reset),
    .req0_valid(req_v[0]), .req0_ready(req0_ready), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req1_valid(req_v[1]), .req1_ready(req1_ready), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_rdy[0]), .rsp0_data(rsp0_data), .rsp0_status(rsp0_status),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_rdy[1]), .rsp1_data(rsp1_data), .rsp1_status(rsp1_status),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
    .busy(busy), .grant_id(grant_id), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rv(input int i);
    return (i == 1) ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int i);
    return (i == 1) ? rsp1_data : rsp0_data;
  endfunction
  function automatic logic [3:0] get_rs(input int i);
    return (i == 1) ? rsp1_status : rsp0_status;
  endfunction

  function automatic int exp_grant();
    if (pend[0] && pend[1]) return 1 - last_g;
    if (pend[1]) return 1;
    return 0;
  endfunction

  task automatic new_req(input int i);
    pend[i]  = 1'b1;
    req_a[i] = $urandom;
    req_b[i] = $urandom;
  endtask

  // Called just before the accept edge of requester g. dly<0 keeps rsp ready
  // high from acceptance; otherwise ready rises dly cycles after rsp valid.
  task automatic serve(input int g, input int dly);
    logic [31:0] ea, eb, ed, od;
    logic [3:0]  es, os;
    int          k;
    logic        bad_hold, bad_other, bad_rdy, bad_bp;
    ea = req_a[g];
    eb = req_b[g];
    ed = fix_en ? fix_data : (ea + eb);
    es = fix_en ? fix_st : (ea[3:0] ^ eb[7:4]);
    od = get_rd(1 - g);
    os = get_rs(1 - g);
    bad_hold = 1'b0; bad_other = 1'b0; bad_rdy = 1'b0; bad_bp = 1'b0;
    if (dly < 0) rsp_rdy[g] = 1'b1;
    @(posedge clk); #2;
    req_v[g] = 1'b0;
    pend[g]  = 1'b0;
    #1;
    chk("op_a_after_accept", fpu_op_a, ea);
    chk("op_b_after_accept", fpu_op_b, eb);
    chk("busy_after_accept", busy, 1);
    chk("grant_id", grant_id, g);
    chk("ready_while_busy", {req1_ready, req0_ready}, 0);
    k = 0;
    while (!get_rv(g) && k < F + 10) begin
      @(posedge clk); #2;
      k++;
      if (fpu_op_a !== ea || fpu_op_b !== eb) bad_hold = 1'b1;
      if (get_rv(1 - g)) bad_other = 1'b1;
      #1;
      if ({req1_ready, req0_ready} != 2'b00) bad_rdy = 1'b1;
    end
    chk("rsp_latency", k, F + 1);
    chk("rsp_data", get_rd(g), ed);
    chk("rsp_status", get_rs(g), es);
    if (dly > 0) begin
      repeat (dly) begin
        @(posedge clk); #2;
        if (!get_rv(g) || get_rd(g) !== ed || get_rs(g) !== es || busy !== 1'b1) bad_bp = 1'b1;
        #1;
        if ({req1_ready, req0_ready} != 2'b00) bad_bp = 1'b1;
      end
      chk("backpressure_hold", bad_bp, 0);
    end
    rsp_rdy[g] = 1'b1;
    @(posedge clk); #2;
    rsp_rdy[g] = 1'b0;
    m_ops  = m_ops + 1'b1;
    last_g = g;
    chk("rsp_valid_cleared", get_rv(g), 0);
    chk("ops_done", ops_done, m_ops);
    chk("busy_after_done", busy, 0);
    chk("other_data_untouched", get_rd(1 - g), od);
    chk("other_status_untouched", get_rs(1 - g), os);
    chk("operands_held", bad_hold, 0);
    chk("other_rsp_quiet", bad_other, 0);
    chk("no_ready_in_flight", bad_rdy, 0);
  endtask

  task automatic present_and_serve(input int dly);
    int g;
    req_v = pend;
    #1;
    g = exp_grant();
    chk("req0_ready", req0_ready, (g == 0) && pend[0]);
    chk("req1_ready", req1_ready, (g == 1) && pend[1]);
    serve(g, dly);
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    reset = 1'b0; req_v = 2'b11; rsp_rdy = 2'b00; fix_en = 1'b0;
    fix_data = 32'h3F200000; fix_st = 4'b0001;
    req_a[0] = 32'h11111111; req_b[0] = 32'h22222222;
    req_a[1] = 32'h33333333; req_b[1] = 32'h44444444;
    last_g = 1; m_ops = '0; pend = 2'b00;

    // Reset held for 3 cycles with both requesters valid.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_rsp_status", {rsp1_status, rsp0_status}, 0);
    chk("rst_fpu_op_a", fpu_op_a, 0);
    chk("rst_fpu_op_b", fpu_op_b, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);

    // Single op on requester 0 with the fixed stub result.
    reset = 1'b1; fix_en = 1'b1;
    req_a[0] = 32'h3E000000; req_b[0] = 32'h3E800000;
    pend = 2'b01;
    present_and_serve(0);
    chk("single_rsp1_valid", rsp1_valid, 0);
    chk("single_rsp1_data", rsp1_data, 0);
    chk("single_ops_done", ops_done, 1);
    fix_en = 1'b0;

    // Mid-operation reset while the settle counter reads 10.
    new_req(1);
    req_v = pend;
    #1;
    chk("midrst_ready1", req1_ready, 1);
    @(posedge clk); #2;
    req_v = 2'b00; pend = 2'b00;
    repeat (F - 11) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    m_ops = '0; last_g = 1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("midrst_ops_done", ops_done, 0);
    bad = 1'b0;
    repeat (F + 5) begin
      @(posedge clk); #2;
      if (rsp1_valid || rsp0_valid || busy) bad = 1'b1;
    end
    chk("midrst_no_response", bad, 0);

    // Valid dropped before acceptance is not taken.
    req_v = 2'b10;
    #1;
    chk("drop_ready1", req1_ready, 1);
    req_v = 2'b00;
    @(posedge clk); #2;
    chk("drop_not_accepted", busy, 0);

    // Contention: both valid, response ready held high, grants alternate.
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      present_and_serve(-1);
      new_req(last_g);
    end
    chk("contention_ops_done", ops_done, 4);
    chk("contention_last_grant", grant_id, 1);

    // Backpressure: response held for 20 cycles, other requester waits.
    present_and_serve(20);
    #1;
    chk("bp_other_ready_next", last_g == 0 ? req1_ready : req0_ready, 1);

    // Randomized traffic; ops_done wraps at 2^CW under the model.
    for (int it = 0; it < 30; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(1) == 1) new_req(r);
      if (pend == 2'b00) new_req(int'($urandom_range(1)));
      present_and_serve(int'($urandom_range(5)) - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
